// File: rtl/pixel_write_queue_if.sv
// Pixel stream in, framebuffer write port out; the animation side is master, the queue is slave.
interface pixel_write_queue_if #(
  parameter int COLOUR_W = 9,
  parameter int ADDR_W   = 15
);
  logic [7:0]          iX;
  logic [6:0]          iY;
  logic [COLOUR_W-1:0] iColour;
  logic                iPlot;
  logic                iFlush;
  logic                iReady;
  logic [ADDR_W-1:0]   oAddress;
  logic [COLOUR_W-1:0] oData;
  logic                oWren;
  logic                oFull;
  logic                oBusy;
  logic [7:0]          oDropCount;

  modport master (
    output iX, iY, iColour, iPlot, iFlush, iReady,
    input  oAddress, oData, oWren, oFull, oBusy, oDropCount
  );

  modport slave (
    input  iX, iY, iColour, iPlot, iFlush, iReady,
    output oAddress, oData, oWren, oFull, oBusy, oDropCount
  );
endinterface

// File: rtl/pixel_write_queue.sv
// Pixel -> linear framebuffer address FIFO; one-cycle latency into an empty queue, show-ahead head.
// iReady stalls the head; off-screen or overflow pixels are dropped and counted (saturating).
module pixel_write_queue #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int COLOUR_W = 9,
  parameter int ADDR_W   = 15,
  parameter int DEPTH    = 8
) (
  input logic               clock,
  input logic               resetn,
  pixel_write_queue_if.slave pix
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [7:0]    MAX_X = 8'(SCREEN_W);
  localparam logic [6:0]    MAX_Y = 7'(SCREEN_H);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [COLOUR_W-1:0] colour;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [7:0]        drop_q, drop_d;

  logic [ADDR_W-1:0] y_ext;
  logic [ADDR_W-1:0] pix_addr;
  logic              on_screen;
  logic              not_empty;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  entry_t            head;

  // y*160 as two shifts so no multiplier is needed.
  always_comb begin
    y_ext    = ADDR_W'(pix.iY);
    pix_addr = (y_ext << 7) + (y_ext << 5) + ADDR_W'(pix.iX);
  end

  assign on_screen = (pix.iX < MAX_X) && (pix.iY < MAX_Y);
  assign not_empty = (count_q != '0);
  assign full      = (count_q == FULL_COUNT);
  assign pop       = not_empty && pix.iReady && !pix.iFlush;
  // A pop on the same edge frees a slot, so a full queue can still accept.
  assign push      = pix.iPlot && on_screen && !pix.iFlush && (!full || pop);
  assign drop      = pix.iPlot && !pix.iFlush && (!on_screen || (full && !pop));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (pix.iFlush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
    if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the queue is empty.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= '{addr: pix_addr, colour: pix.iColour};
  end

  assign head           = mem_q[rd_ptr_q];
  assign pix.oWren      = not_empty;
  assign pix.oBusy      = not_empty;
  assign pix.oFull      = full;
  assign pix.oAddress   = not_empty ? head.addr   : '0;
  assign pix.oData      = not_empty ? head.colour : '0;
  assign pix.oDropCount = drop_q;
endmodule
